stepper_motion_ctrl: RTL

//  Upstream motion sequencer for the full-step bipolar stepper driver.

---
 rtl/stepper_motion_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/stepper_motion_ctrl.sv
// Move sequencer for a full-step bipolar stepper driver: accepts move commands,
// generates the driver step clock and control code, and stops cleanly at end stops.
module stepper_motion_ctrl #(
  parameter int unsigned P_STEP_W = 8,
  parameter int unsigned P_DIV_W  = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_dir,
  input  logic [P_STEP_W-1:0] i_cmd_steps,
  input  logic [P_DIV_W-1:0]  i_half_period,
  input  logic                i_abort,
  input  logic [1:0]          i_pos,
  output logic                o_step_clk,
  output logic [3:0]          o_control,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_limit,
  output logic [P_STEP_W-1:0] o_steps_left
);

  localparam logic [1:0] POS_ZERO  = 2'b00;
  localparam logic [1:0] POS_LIMIT = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                dir_q, dir_d;
  logic [P_DIV_W-1:0]  half_q, half_d;
  logic [P_DIV_W-1:0]  div_q, div_d;
  logic                step_clk_d;
  logic [3:0]          control_d;
  logic                busy_d, done_d, limit_d, ready_d;
  logic [P_STEP_W-1:0] steps_left_d;

  logic accept_c, cmd_blocked_c, cmd_zero_c;
  logic toggle_c, rise_c, fall_c, at_end_c, stop_c;

  // Handshake and event decode shared by both combinational processes
  always_comb begin
    accept_c      = (state_q == S_IDLE) && i_cmd_valid && o_cmd_ready;
    cmd_zero_c    = (i_cmd_steps == '0);
    cmd_blocked_c = i_cmd_dir ? (i_pos == POS_LIMIT) : (i_pos == POS_ZERO);
    toggle_c      = ((state_q == S_RUN) || (state_q == S_FLUSH)) &&
                    (div_q == (half_q - P_DIV_W'(1)));
    rise_c        = toggle_c && !o_step_clk;
    fall_c        = toggle_c && o_step_clk;
    at_end_c      = dir_q ? (i_pos == POS_LIMIT) : (i_pos == POS_ZERO);
    stop_c        = (state_q == S_RUN) && fall_c &&
                    ((o_steps_left == '0) || i_abort || at_end_c);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = (cmd_zero_c || cmd_blocked_c) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (stop_c) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fall_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    dir_d        = dir_q;
    half_d       = half_q;
    div_d        = div_q;
    step_clk_d   = o_step_clk;
    control_d    = o_control;
    limit_d      = o_limit;
    steps_left_d = o_steps_left;
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d == S_RUN) || (state_d == S_FLUSH);
    ready_d      = (state_d == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          dir_d        = i_cmd_dir;
          half_d       = (i_half_period == '0) ? P_DIV_W'(1) : i_half_period;
          div_d        = '0;
          steps_left_d = i_cmd_steps;
          limit_d      = 1'b0;
          if (state_d == S_RUN) begin
            control_d = {2'b00, ~i_cmd_dir, i_cmd_dir};
          end else if (!cmd_zero_c) begin
            limit_d = 1'b1;
          end
        end
      end
      S_RUN, S_FLUSH: begin
        if (toggle_c) begin
          step_clk_d = ~o_step_clk;
          div_d      = '0;
        end else begin
          div_d = div_q + P_DIV_W'(1);
        end
        if ((state_q == S_RUN) && rise_c) begin
          steps_left_d = o_steps_left - P_STEP_W'(1);
        end
        // Early exit keeps the remaining count visible and flags the limit
        if (stop_c) begin
          control_d = 4'b0000;
          if (o_steps_left != '0) begin
            limit_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        step_clk_d = 1'b0;
        control_d  = 4'b0000;
      end
      default: begin
        step_clk_d = 1'b0;
        control_d  = 4'b0000;
      end
    endcase
  end

  // Registered outputs and command latch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir_q        <= 1'b0;
      half_q       <= P_DIV_W'(1);
      div_q        <= '0;
      o_step_clk   <= 1'b0;
      o_control    <= 4'b0000;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_limit      <= 1'b0;
      o_steps_left <= '0;
      o_cmd_ready  <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      half_q       <= half_d;
      div_q        <= div_d;
      o_step_clk   <= step_clk_d;
      o_control    <= control_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_limit      <= limit_d;
      o_steps_left <= steps_left_d;
      o_cmd_ready  <= ready_d;
    end
  end

endmodule
